sa_skew_sr: RTL and testbench

Multi-lane, parametrised skew shift register that feeds the systolic array's edge (or realigns its outputs). It gives each of `CHANNELS` data lanes its own delay, `D(k)`, which grows linearly with the lane index. It adds a global advance/stall control, a synchronous flush and an in-flight occupancy counter on top of the plain single-lane delay line. It sits between the operand buffers and the array's row/column inputs, or between the array outputs and the result collector when `REVERSE=1`.

---
 rtl/sa_skew_sr.sv | 98 +++++++++
 tb/tb_sa_skew_sr.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_skew_sr.sv
// sa_skew_sr: multi-lane skew delay line (lane k delayed BASE+STEP*idx(k)) with stall, flush and occupancy count.
// Define SA_SKEW_SR_DATA_RST_EN to also reset the data registers to zero.
module sa_skew_sr #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned BASE     = 1,
    parameter int unsigned STEP     = 1,
    parameter int unsigned REVERSE  = 0,
    localparam int unsigned DMAX    = BASE + STEP * (CHANNELS - 1),
    localparam int unsigned CW      = $clog2(CHANNELS * DMAX + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_en,
    input  logic                      i_flush,
    input  logic [CHANNELS-1:0]       i_vld,
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    output logic [CHANNELS-1:0]       o_vld,
    output logic [CHANNELS*WIDTH-1:0] o_data,
    output logic [CW-1:0]             o_cnt,
    output logic                      o_busy
);

    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic [CW-1:0] popcnt(input logic [CHANNELS-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        localparam int unsigned IDX = (REVERSE != 0) ? (CHANNELS - 1 - k) : k;
        localparam int unsigned DK  = BASE + STEP * IDX;

        // Only DK stages per lane; stage DK-1 drives the outputs directly.
        logic [DK-1:0]    vld_q, vld_d;
        logic [WIDTH-1:0] dat_q [DK];
        logic [WIDTH-1:0] dat_d [DK];

        always_comb begin
            vld_d = vld_q;
            if (i_flush) begin
                vld_d = '0;
            end else if (i_en) begin
                vld_d[0] = i_vld[k];
                for (int unsigned j = 1; j < DK; j++) vld_d[j] = vld_q[j-1];
            end
        end

        always_comb begin
            dat_d = dat_q;
            if (i_en && !i_flush) begin
                dat_d[0] = i_data[k*WIDTH +: WIDTH];
                for (int unsigned j = 1; j < DK; j++) dat_d[j] = dat_q[j-1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) vld_q <= '0;
            else        vld_q <= vld_d;
        end

`ifdef SA_SKEW_SR_DATA_RST_EN
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int unsigned j = 0; j < DK; j++) dat_q[j] <= '0;
            end else begin
                dat_q <= dat_d;
            end
        end
`else
        always_ff @(posedge clk) begin
            dat_q <= dat_d;
        end
`endif

        assign o_vld[k]                  = vld_q[DK-1];
        assign o_data[k*WIDTH +: WIDTH] = dat_q[DK-1];
    end

    // Entries in minus entries leaving through the last stages keeps the count exact.
    always_comb begin
        cnt_d = cnt_q;
        if (i_flush)   cnt_d = '0;
        else if (i_en) cnt_d = cnt_q + popcnt(i_vld) - popcnt(o_vld);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign o_cnt  = cnt_q;
    assign o_busy = (cnt_q != '0);

endmodule

// File: tb/tb_sa_skew_sr.sv
// Directed and scoreboarded checks of sa_skew_sr: forward skew, reversed skew,
// stalls, flush, asynchronous reset and a randomized BASE=2/STEP=3/C=5 instance.
module tb_sa_skew_sr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, flush;
    logic [3:0]  vld;
    logic [63:0] data;

    logic [3:0]  d_vld, rv_vld;
    logic [63:0] d_data, rv_data;
    logic [4:0]  d_cnt, rv_cnt;
    logic        d_busy, rv_busy;

    logic        x_en, x_flush;
    logic [4:0]  x_vld, xo_vld;
    logic [79:0] x_data, xo_data;
    logic [6:0]  xo_cnt;
    logic        xo_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sa_skew_sr u_dut (
        .clk(clk), .rst_n(rst_n), .i_en(en), .i_flush(flush), .i_vld(vld), .i_data(data),
        .o_vld(d_vld), .o_data(d_data), .o_cnt(d_cnt), .o_busy(d_busy)
    );

    sa_skew_sr #(.REVERSE(1)) u_rev (
        .clk(clk), .rst_n(rst_n), .i_en(en), .i_flush(flush), .i_vld(vld), .i_data(data),
        .o_vld(rv_vld), .o_data(rv_data), .o_cnt(rv_cnt), .o_busy(rv_busy)
    );

    sa_skew_sr #(.WIDTH(16), .CHANNELS(5), .BASE(2), .STEP(3)) u_rnd (
        .clk(clk), .rst_n(rst_n), .i_en(x_en), .i_flush(x_flush), .i_vld(x_vld), .i_data(x_data),
        .o_vld(xo_vld), .o_data(xo_data), .o_cnt(xo_cnt), .o_busy(xo_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0; flush = 1'b0; vld = '0; data = '0;
        x_en = 1'b0; x_flush = 1'b0; x_vld = '0; x_data = '0;
        #12;
        total++; if (d_vld !== 4'h0) begin bad++; $display("FAIL reset_vld: got %0h want 0", d_vld); end
        total++; if (d_cnt !== 5'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", d_cnt); end
        total++; if (d_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", d_busy); end
        total++; if (rv_vld !== 4'h0) begin bad++; $display("FAIL reset_rev_vld: got %0h want 0", rv_vld); end
        total++; if (rv_busy !== 1'b0) begin bad++; $display("FAIL reset_rev_busy: got %0b want 0", rv_busy); end
        total++; if (xo_vld !== 5'h0) begin bad++; $display("FAIL reset_rnd_vld: got %0h want 0", xo_vld); end
        total++; if (xo_cnt !== 7'd0) begin bad++; $display("FAIL reset_rnd_cnt: got %0d want 0", xo_cnt); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_skew();
        logic [3:0]  exp_v;
        logic [4:0]  exp_c;
        logic [15:0] exp_d;
        en = 1'b1; flush = 1'b0; vld = 4'hF;
        data = {16'hA3, 16'hA2, 16'hA1, 16'hA0};
        for (int e = 1; e <= 5; e++) begin
            tick();
            vld = '0; data = '0;
            exp_v = (e <= 4) ? 4'(1 << (e - 1)) : 4'h0;
            exp_c = 5'(5 - e);
            total++; if (d_vld !== exp_v) begin bad++; $display("FAIL skew_vld e=%0d: got %0h want %0h", e, d_vld, exp_v); end
            total++; if (d_cnt !== exp_c) begin bad++; $display("FAIL skew_cnt e=%0d: got %0d want %0d", e, d_cnt, exp_c); end
            total++; if (d_busy !== (e < 5)) begin bad++; $display("FAIL skew_busy e=%0d: got %0b want %0b", e, d_busy, (e < 5)); end
            for (int k = 0; k < 4; k++) begin
                exp_d = 16'(16'hA0 + k);
                if (exp_v[k]) begin
                    total++;
                    if (d_data[k*16 +: 16] !== exp_d) begin
                        bad++; $display("FAIL skew_data lane=%0d: got %0h want %0h", k, d_data[k*16 +: 16], exp_d);
                    end
                end
            end
        end
    endtask

    task automatic test_reverse();
        logic [3:0]  exp_v;
        logic [4:0]  exp_c;
        logic [15:0] exp_d;
        en = 1'b1; flush = 1'b0; vld = 4'hF;
        data = {16'hA3, 16'hA2, 16'hA1, 16'hA0};
        for (int e = 1; e <= 5; e++) begin
            tick();
            vld = '0; data = '0;
            exp_v = (e <= 4) ? 4'(8 >> (e - 1)) : 4'h0;
            exp_c = 5'(5 - e);
            total++; if (rv_vld !== exp_v) begin bad++; $display("FAIL rev_vld e=%0d: got %0h want %0h", e, rv_vld, exp_v); end
            total++; if (rv_cnt !== exp_c) begin bad++; $display("FAIL rev_cnt e=%0d: got %0d want %0d", e, rv_cnt, exp_c); end
            for (int k = 0; k < 4; k++) begin
                exp_d = 16'(16'hA0 + k);
                if (exp_v[k]) begin
                    total++;
                    if (rv_data[k*16 +: 16] !== exp_d) begin
                        bad++; $display("FAIL rev_data lane=%0d: got %0h want %0h", k, rv_data[k*16 +: 16], exp_d);
                    end
                end
            end
        end
    endtask

    task automatic test_stall_ramp();
        int adv = 0;
        logic [3:0] exp_v;
        logic [4:0] exp_c;
        flush = 1'b0; vld = 4'b0100;
        for (int c = 0; c < 24; c++) begin
            en = (c % 2 == 0);
            data = '0;
            data[47:32] = 16'(adv);
            tick();
            if (en) adv++;
            exp_v = (adv >= 3) ? 4'b0100 : 4'b0000;
            exp_c = (adv >= 3) ? 5'd3 : 5'(adv);
            total++; if (d_vld !== exp_v) begin bad++; $display("FAIL ramp_vld c=%0d: got %0h want %0h", c, d_vld, exp_v); end
            total++; if (d_cnt !== exp_c) begin bad++; $display("FAIL ramp_cnt c=%0d: got %0d want %0d", c, d_cnt, exp_c); end
            if (adv >= 3) begin
                total++;
                if (d_data[47:32] !== 16'(adv - 3)) begin
                    bad++; $display("FAIL ramp_data c=%0d: got %0d want %0d", c, d_data[47:32], adv - 3);
                end
            end
        end
        vld = '0; en = 1'b1; data = '0;
        repeat (4) tick();
    endtask

    task automatic test_flush();
        logic [4:0] exp_c;
        en = 1'b1; flush = 1'b0; vld = 4'hF;
        data = 64'h1111_2222_3333_4444;
        for (int e = 1; e <= 5; e++) begin
            tick();
            exp_c = (e == 1) ? 5'd4 : (e == 2) ? 5'd7 : (e == 3) ? 5'd9 : 5'd10;
            total++; if (d_cnt !== exp_c) begin bad++; $display("FAIL fill_cnt e=%0d: got %0d want %0d", e, d_cnt, exp_c); end
        end
        total++; if (d_vld !== 4'hF) begin bad++; $display("FAIL fill_vld: got %0h want f", d_vld); end
        flush = 1'b1;
        tick();
        flush = 1'b0; en = 1'b0;
        total++; if (d_vld !== 4'h0) begin bad++; $display("FAIL flush_vld: got %0h want 0", d_vld); end
        total++; if (d_cnt !== 5'd0) begin bad++; $display("FAIL flush_cnt: got %0d want 0", d_cnt); end
        total++; if (d_busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %0b want 0", d_busy); end
        tick();
        total++; if (d_cnt !== 5'd0) begin bad++; $display("FAIL stall_ignore_cnt: got %0d want 0", d_cnt); end
        total++; if (d_vld !== 4'h0) begin bad++; $display("FAIL stall_ignore_vld: got %0h want 0", d_vld); end
        vld = '0; en = 1'b1;
    endtask

    task automatic test_async_reset();
        en = 1'b1; flush = 1'b0; vld = 4'hF;
        data = 64'hDEAD_BEEF_CAFE_F00D;
        tick();
        tick();
        total++; if (d_cnt !== 5'd7) begin bad++; $display("FAIL pre_rst_cnt: got %0d want 7", d_cnt); end
        total++; if (d_busy !== 1'b1) begin bad++; $display("FAIL pre_rst_busy: got %0b want 1", d_busy); end
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (d_vld !== 4'h0) begin bad++; $display("FAIL arst_vld: got %0h want 0", d_vld); end
        total++; if (d_cnt !== 5'd0) begin bad++; $display("FAIL arst_cnt: got %0d want 0", d_cnt); end
        total++; if (d_busy !== 1'b0) begin bad++; $display("FAIL arst_busy: got %0b want 0", d_busy); end
`ifdef SA_SKEW_SR_DATA_RST_EN
        total++; if (d_data !== 64'h0) begin bad++; $display("FAIL arst_data: got %0h want 0", d_data); end
`endif
        vld = '0;
        #2;
        rst_n = 1'b1;
        tick();
        total++; if (d_cnt !== 5'd0) begin bad++; $display("FAIL post_rst_cnt: got %0d want 0", d_cnt); end
    endtask

    task automatic test_random();
        int unsigned adv = 0;
        int unsigned due_q [5][$];
        logic [15:0] dq    [5][$];
        int unsigned n;
        logic        ev;
        for (int c = 0; c < 10000; c++) begin
            x_en    = ($urandom_range(0, 3) != 0);
            x_flush = ($urandom_range(0, 40) == 0);
            x_vld   = 5'($urandom);
            for (int k = 0; k < 5; k++) x_data[k*16 +: 16] = 16'($urandom);
            tick();
            if (x_flush) begin
                for (int k = 0; k < 5; k++) begin
                    due_q[k].delete();
                    dq[k].delete();
                end
            end else if (x_en) begin
                for (int k = 0; k < 5; k++) begin
                    if (due_q[k].size() > 0 && due_q[k][0] == adv) begin
                        void'(due_q[k].pop_front());
                        void'(dq[k].pop_front());
                    end
                    if (x_vld[k]) begin
                        due_q[k].push_back(adv + 2 + 3 * k);
                        dq[k].push_back(x_data[k*16 +: 16]);
                    end
                end
                adv++;
            end
            n = 0;
            for (int k = 0; k < 5; k++) begin
                n += due_q[k].size();
                ev = (due_q[k].size() > 0) && (due_q[k][0] == adv);
                total++;
                if (xo_vld[k] !== ev) begin
                    bad++; $display("FAIL rnd_vld c=%0d lane=%0d: got %0b want %0b", c, k, xo_vld[k], ev);
                end else if (ev) begin
                    total++;
                    if (xo_data[k*16 +: 16] !== dq[k][0]) begin
                        bad++; $display("FAIL rnd_data c=%0d lane=%0d: got %0h want %0h", c, k, xo_data[k*16 +: 16], dq[k][0]);
                    end
                end
            end
            total++; if (xo_cnt !== 7'(n)) begin bad++; $display("FAIL rnd_cnt c=%0d: got %0d want %0d", c, xo_cnt, n); end
            total++; if (xo_busy !== (n != 0)) begin bad++; $display("FAIL rnd_busy c=%0d: got %0b want %0b", c, xo_busy, (n != 0)); end
        end
        x_en = 1'b0; x_flush = 1'b0; x_vld = '0;
    endtask

    initial begin
        test_reset();
        test_skew();
        test_reverse();
        test_stall_ramp();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
